// File: rtl/mmu_hs.sv
// mmu_hs: request/ready memory unit with internal RAM, IO channels and timeout
module mmu_hs #(
    parameter int RAM_WORDS_LOG = 14,
    parameter int IO_PORTS = 4,
    parameter int IO_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [31:0]         dm_addr,
    input  logic [31:0]         dm_di,
    input  logic [3:0]          dm_be,
    input  logic                is_signed,
    output logic [31:0]         dm_do,
    output logic                dm_ready,
    output logic                dm_fault,
    output logic [1:0]          dm_cause,
    output logic                io_req,
    output logic [IO_PORTS-1:0] io_sel,
    output logic [5:0]          io_addr,
    output logic                io_we,
    output logic [3:0]          io_be,
    output logic [31:0]         io_wdata,
    input  logic [31:0]         io_rdata,
    input  logic                io_ack
);
    localparam logic [1:0] IDLE = 2'd0, IO_WAIT = 2'd1, RESP = 2'd2;
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [29:0] off;
    logic [RAM_WORDS_LOG-1:0] ram_addr;
    logic legal, ram_hit, io_hit, start, ram_we, ram_re;
    logic [31:0] wdata, raw, sh, ext, dm_do_q, dm_do_d;
    logic [31:0] mem [2**RAM_WORDS_LOG];
    logic [31:0] ram_rd_q, io_rd_q, io_rd_d;
    logic src_io_q, src_io_d, sgn_q, sgn_d;
    logic [3:0] be_q, be_d;
    logic dm_fault_q, dm_fault_d;
    logic [1:0] dm_cause_q, dm_cause_d;
    logic io_req_q, io_req_d, io_we_q, io_we_d;
    logic [IO_PORTS-1:0] io_sel_q, io_sel_d;
    logic [5:0] io_addr_q, io_addr_d;
    logic [3:0] io_be_q, io_be_d;
    logic [31:0] io_wdata_q, io_wdata_d;
    always_comb begin
        off = dm_addr[31:2] - 30'h0400_0000;
        ram_addr = off[RAM_WORDS_LOG-1:0];
        ram_hit = off[29:RAM_WORDS_LOG] == '0;
        io_hit = dm_addr[31:8] == 24'h80_0000 && {1'b0, dm_addr[7:6]} < 3'(IO_PORTS);
        legal = (dm_be == 4'b1111 && dm_addr[1:0] == 2'd0) || (dm_be == 4'b0011 && dm_addr[1:0] == 2'd0)
             || (dm_be == 4'b1100 && dm_addr[1:0] == 2'd2) || (dm_be == 4'b0001 && dm_addr[1:0] == 2'd0)
             || (dm_be == 4'b0010 && dm_addr[1:0] == 2'd1) || (dm_be == 4'b0100 && dm_addr[1:0] == 2'd2)
             || (dm_be == 4'b1000 && dm_addr[1:0] == 2'd3);
        start = state_q == IDLE && dm_req;
        ram_we = start && legal && ram_hit && dm_we && !reset;
        ram_re = start && legal && ram_hit && !dm_we;
        wdata = dm_di << {dm_addr[1:0], 3'b000};
        raw = src_io_q ? io_rd_q : ram_rd_q;
        sh = be_q[0] ? raw : be_q[1] ? raw >> 8 : be_q[2] ? raw >> 16 : raw >> 24;
        ext = &be_q ? sh
            : (be_q == 4'b0011 || be_q == 4'b1100) ? {{16{sgn_q & sh[15]}}, sh[15:0]}
            : {{24{sgn_q & sh[7]}}, sh[7:0]};
        dm_do_d = state_q == RESP ? (dm_fault_q ? 32'd0 : ext) : dm_do_q;
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        be_d = be_q;
        sgn_d = sgn_q;
        src_io_d = src_io_q;
        io_rd_d = io_rd_q;
        dm_fault_d = dm_fault_q;
        dm_cause_d = dm_cause_q;
        io_req_d = io_req_q;
        io_sel_d = io_sel_q;
        io_addr_d = io_addr_q;
        io_we_d = io_we_q;
        io_be_d = io_be_q;
        io_wdata_d = io_wdata_q;
        if (start) begin
            be_d = dm_be;
            sgn_d = is_signed;
            src_io_d = 1'b0;
            dm_fault_d = !legal || !(ram_hit || io_hit);
            dm_cause_d = !legal ? 2'b01 : !(ram_hit || io_hit) ? 2'b10 : 2'b00;
            state_d = RESP;
            if (legal && io_hit) begin
                state_d = IO_WAIT;
                cnt_d = '0;
                src_io_d = 1'b1;
                io_req_d = 1'b1;
                io_sel_d = IO_PORTS'(1) << dm_addr[7:6];
                io_addr_d = dm_addr[5:0];
                io_we_d = dm_we;
                io_be_d = dm_be;
                io_wdata_d = wdata;
            end
        end else if (state_q == IO_WAIT) begin
            if (io_ack) begin
                io_rd_d = io_rdata;
                io_req_d = 1'b0;
                dm_fault_d = 1'b0;
                dm_cause_d = 2'b00;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(IO_TIMEOUT - 1)) begin
                    io_req_d = 1'b0;
                    dm_fault_d = 1'b1;
                    dm_cause_d = 2'b11;
                    state_d = RESP;
                end
            end
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            be_q <= '0;
            sgn_q <= 1'b0;
            src_io_q <= 1'b0;
            io_rd_q <= '0;
            dm_do_q <= '0;
            dm_fault_q <= 1'b0;
            dm_cause_q <= 2'b00;
            io_req_q <= 1'b0;
            io_sel_q <= '0;
            io_addr_q <= '0;
            io_we_q <= 1'b0;
            io_be_q <= '0;
            io_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            be_q <= be_d;
            sgn_q <= sgn_d;
            src_io_q <= src_io_d;
            io_rd_q <= io_rd_d;
            dm_do_q <= dm_do_d;
            dm_fault_q <= dm_fault_d;
            dm_cause_q <= dm_cause_d;
            io_req_q <= io_req_d;
            io_sel_q <= io_sel_d;
            io_addr_q <= io_addr_d;
            io_we_q <= io_we_d;
            io_be_q <= io_be_d;
            io_wdata_q <= io_wdata_d;
        end
    end
    always_ff @(posedge clk) begin
        if (ram_we)
            for (int i = 0; i < 4; i++)
                if (dm_be[i]) mem[ram_addr][8*i +: 8] <= wdata[8*i +: 8];
        if (ram_re) ram_rd_q <= mem[ram_addr];
    end
    assign dm_do = dm_do_d;
    assign dm_ready = state_q == RESP;
    assign dm_fault = dm_fault_q;
    assign dm_cause = dm_cause_q;
    assign io_req = io_req_q;
    assign io_sel = io_sel_q;
    assign io_addr = io_addr_q;
    assign io_we = io_we_q;
    assign io_be = io_be_q;
    assign io_wdata = io_wdata_q;
endmodule

// File: tb/tb_mmu_hs.sv
// tb_mmu_hs: directed table plus IO/timeout/reset sequences for mmu_hs
module tb_mmu_hs;
    logic clk, reset, dm_req, dm_we, is_signed, dm_ready, dm_fault, io_req, io_we, io_ack;
    logic [31:0] dm_addr, dm_di, dm_do, io_wdata, io_rdata;
    logic [3:0] dm_be, io_be, io_sel;
    logic [1:0] dm_cause;
    logic [5:0] io_addr;
    int n_chk = 0, n_fail = 0;
    int ack_delay = -1, wcnt = 0;
    logic [31:0] ack_data = '0;
    logic [46:0] io_first;
    int io_unstable;
    typedef struct {
        logic we;
        logic [31:0] addr, di;
        logic [3:0] be;
        logic sgn, cd;
        logic [31:0] edo;
        logic ef;
        logic [1:0] ec;
    } vec_t;
    vec_t v[$];
    mmu_hs dut (
        .clk(clk), .reset(reset), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_di(dm_di), .dm_be(dm_be), .is_signed(is_signed), .dm_do(dm_do),
        .dm_ready(dm_ready), .dm_fault(dm_fault), .dm_cause(dm_cause), .io_req(io_req),
        .io_sel(io_sel), .io_addr(io_addr), .io_we(io_we), .io_be(io_be),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        io_ack = 1'b0;
        io_rdata = '0;
        forever begin
            @(negedge clk);
            io_ack = 1'b0;
            if (io_req && ack_delay >= 0 && wcnt == ack_delay) begin
                io_ack = 1'b1;
                io_rdata = ack_data;
            end
            wcnt = io_req ? wcnt + 1 : 0;
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic add(input logic we, input logic [31:0] addr, di, input logic [3:0] be,
                       input logic sgn, cd, input logic [31:0] edo, input logic ef, input logic [1:0] ec);
        vec_t t;
        t.we = we; t.addr = addr; t.di = di; t.be = be; t.sgn = sgn;
        t.cd = cd; t.edo = edo; t.ef = ef; t.ec = ec;
        v.push_back(t);
    endtask
    task automatic access(input logic we, input logic [31:0] addr, di, input logic [3:0] be,
                          input logic sgn, output logic [31:0] rdo, output logic rf,
                          output logic [1:0] rc, output int lat, output int reqc);
        dm_we = we; dm_addr = addr; dm_di = di; dm_be = be; is_signed = sgn; dm_req = 1'b1;
        lat = 0;
        reqc = 0;
        io_unstable = 0;
        do begin
            @(negedge clk);
            lat++;
            if (io_req) begin
                if (reqc == 0) io_first = {io_sel, io_addr, io_we, io_be, io_wdata};
                else if ({io_sel, io_addr, io_we, io_be, io_wdata} !== io_first) io_unstable++;
                reqc++;
            end
        end while (!dm_ready && lat < 64);
        chk("ready_seen", {31'd0, dm_ready}, 32'd1);
        rdo = dm_do;
        rf = dm_fault;
        rc = dm_cause;
        dm_req = 1'b0;
        @(negedge clk);
        chk("ready_one_cycle", {31'd0, dm_ready}, 32'd0);
    endtask
    initial begin
        logic [31:0] rdo;
        logic rf;
        logic [1:0] rc;
        int lat, reqc, ready_cnt;
        reset = 1'b1; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_di = '0; dm_be = '0; is_signed = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, dm_ready}, 32'd0);
        chk("rst_fault", {31'd0, dm_fault}, 32'd0);
        chk("rst_cause", {30'd0, dm_cause}, 32'd0);
        chk("rst_do", dm_do, 32'd0);
        chk("rst_io_req", {31'd0, io_req}, 32'd0);
        chk("rst_io_sel", {28'd0, io_sel}, 32'd0);
        chk("rst_io_we", {31'd0, io_we}, 32'd0);
        reset = 1'b0;
        add(1, 32'h1000_0010, 32'hDEAD_BEEF, 4'b1111, 0, 0, 32'h0, 0, 2'b00);
        add(0, 32'h1000_0012, 32'h0, 4'b0100, 1, 1, 32'hFFFF_FFAD, 0, 2'b00);
        add(0, 32'h1000_0012, 32'h0, 4'b0100, 0, 1, 32'h0000_00AD, 0, 2'b00);
        add(0, 32'h1000_0010, 32'h0, 4'b1111, 1, 1, 32'hDEAD_BEEF, 0, 2'b00);
        add(0, 32'h1000_0010, 32'h0, 4'b0011, 1, 1, 32'hFFFF_BEEF, 0, 2'b00);
        add(0, 32'h1000_0012, 32'h0, 4'b1100, 0, 1, 32'h0000_DEAD, 0, 2'b00);
        add(0, 32'h1000_0013, 32'h0, 4'b1000, 1, 1, 32'hFFFF_FFDE, 0, 2'b00);
        add(0, 32'h1000_0011, 32'h0, 4'b0010, 0, 1, 32'h0000_00BE, 0, 2'b00);
        add(0, 32'h1000_0010, 32'h0, 4'b0001, 1, 1, 32'hFFFF_FFEF, 0, 2'b00);
        add(1, 32'h1000_0011, 32'h0000_0055, 4'b0010, 0, 0, 32'h0, 0, 2'b00);
        add(0, 32'h1000_0010, 32'h0, 4'b1111, 0, 1, 32'hDEAD_55EF, 0, 2'b00);
        add(1, 32'h1000_0012, 32'h0000_1234, 4'b1100, 0, 0, 32'h0, 0, 2'b00);
        add(0, 32'h1000_0010, 32'h0, 4'b1111, 0, 1, 32'h1234_55EF, 0, 2'b00);
        add(0, 32'h1000_0002, 32'h0, 4'b1111, 0, 1, 32'h0, 1, 2'b01);
        add(0, 32'h0000_0100, 32'h0, 4'b1111, 0, 1, 32'h0, 1, 2'b10);
        add(1, 32'h1000_0011, 32'h0, 4'b1111, 0, 1, 32'h0, 1, 2'b01);
        add(0, 32'h1000_0010, 32'h0, 4'b1111, 0, 1, 32'h1234_55EF, 0, 2'b00);
        add(0, 32'h1000_0001, 32'h0, 4'b0001, 0, 1, 32'h0, 1, 2'b01);
        add(0, 32'h1000_0000, 32'h0, 4'b0110, 0, 1, 32'h0, 1, 2'b01);
        add(0, 32'h0000_0102, 32'h0, 4'b1111, 0, 1, 32'h0, 1, 2'b01);
        add(1, 32'h1000_FFFC, 32'hA5A5_A5A5, 4'b1111, 0, 0, 32'h0, 0, 2'b00);
        add(0, 32'h1000_FFFC, 32'h0, 4'b1111, 0, 1, 32'hA5A5_A5A5, 0, 2'b00);
        add(0, 32'h1001_0000, 32'h0, 4'b1111, 0, 1, 32'h0, 1, 2'b10);
        add(0, 32'h0FFF_FFFC, 32'h0, 4'b1111, 0, 1, 32'h0, 1, 2'b10);
        add(0, 32'h8000_0100, 32'h0, 4'b1111, 0, 1, 32'h0, 1, 2'b10);
        add(1, 32'h1000_0000, 32'h0102_0304, 4'b1111, 0, 0, 32'h0, 0, 2'b00);
        add(0, 32'h1000_0000, 32'h0, 4'b1111, 0, 1, 32'h0102_0304, 0, 2'b00);
        add(0, 32'h1000_0010, 32'h0, 4'b1111, 0, 1, 32'h1234_55EF, 0, 2'b00);
        foreach (v[i]) begin
            access(v[i].we, v[i].addr, v[i].di, v[i].be, v[i].sgn, rdo, rf, rc, lat, reqc);
            chk($sformatf("vec%0d_fault", i), {31'd0, rf}, {31'd0, v[i].ef});
            chk($sformatf("vec%0d_cause", i), {30'd0, rc}, {30'd0, v[i].ec});
            chk($sformatf("vec%0d_latency", i), lat, 32'd1);
            if (v[i].cd) begin
                chk($sformatf("vec%0d_do", i), rdo, v[i].edo);
                chk($sformatf("vec%0d_do_hold", i), dm_do, v[i].edo);
            end
        end
        ack_delay = 3; ack_data = 32'h1234_5678;
        access(0, 32'h8000_0084, 32'h0, 4'b1111, 0, rdo, rf, rc, lat, reqc);
        chk("io_rd_sel_addr_we_be", {17'd0, io_first[46:32]}, {17'd0, 4'b0100, 6'h04, 1'b0, 4'b1111});
        chk("io_rd_stable", io_unstable, 32'd0);
        chk("io_rd_do", rdo, 32'h1234_5678);
        chk("io_rd_fault", {31'd0, rf}, 32'd0);
        chk("io_rd_latency", lat, 32'd5);
        chk("io_rd_req_cycles", reqc, 32'd4);
        ack_delay = 0;
        access(1, 32'h8000_00C2, 32'h0000_BEEF, 4'b1100, 0, rdo, rf, rc, lat, reqc);
        chk("io_wr_sel_addr_we_be", {17'd0, io_first[46:32]}, {17'd0, 4'b1000, 6'h02, 1'b1, 4'b1100});
        chk("io_wr_wdata", io_first[31:0], 32'hBEEF_0000);
        chk("io_wr_fault", {31'd0, rf}, 32'd0);
        chk("io_wr_latency", lat, 32'd2);
        ack_delay = 1; ack_data = 32'h80FF_FFFF;
        access(0, 32'h8000_0047, 32'h0, 4'b1000, 1, rdo, rf, rc, lat, reqc);
        chk("io_byte_sel_addr", {22'd0, io_first[46:37]}, {22'd0, 4'b0010, 6'h07});
        chk("io_byte_do", rdo, 32'hFFFF_FF80);
        chk("io_byte_latency", lat, 32'd3);
        ack_delay = -1;
        access(1, 32'h8000_0000, 32'hCAFE_F00D, 4'b1111, 0, rdo, rf, rc, lat, reqc);
        chk("tmo_req_cycles", reqc, 32'd15);
        chk("tmo_stable", io_unstable, 32'd0);
        chk("tmo_wdata", io_first[31:0], 32'hCAFE_F00D);
        chk("tmo_fault", {31'd0, rf}, 32'd1);
        chk("tmo_cause", {30'd0, rc}, 32'd3);
        chk("tmo_do", rdo, 32'd0);
        chk("tmo_latency", lat, 32'd16);
        chk("tmo_req_dropped", {31'd0, io_req}, 32'd0);
        ack_delay = 14; ack_data = 32'h0BAD_F00D;
        access(0, 32'h8000_0040, 32'h0, 4'b1111, 0, rdo, rf, rc, lat, reqc);
        chk("ack_at_tmo_fault", {31'd0, rf}, 32'd0);
        chk("ack_at_tmo_cause", {30'd0, rc}, 32'd0);
        chk("ack_at_tmo_do", rdo, 32'h0BAD_F00D);
        chk("ack_at_tmo_latency", lat, 32'd16);
        ack_delay = -1;
        dm_we = 1'b0; dm_addr = 32'h8000_0000; dm_be = 4'b1111; is_signed = 1'b0; dm_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_io_wait_req_before", {31'd0, io_req}, 32'd1);
        reset = 1'b1;
        dm_req = 1'b0;
        @(negedge clk);
        chk("rst_io_wait_req_after", {31'd0, io_req}, 32'd0);
        chk("rst_io_wait_ready", {31'd0, dm_ready}, 32'd0);
        chk("rst_io_wait_sel", {28'd0, io_sel}, 32'd0);
        reset = 1'b0;
        ready_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (dm_ready) ready_cnt++;
        end
        chk("rst_io_wait_no_ready", ready_cnt, 32'd0);
        access(0, 32'h1000_0010, 32'h0, 4'b1111, 0, rdo, rf, rc, lat, reqc);
        chk("ram_kept_after_reset", rdo, 32'h1234_55EF);
        chk("ram_kept_fault", {31'd0, rf}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mmu_hs.md
MMU_HS -- requirements
Module: mmu_hs

Interface
REQ-001 The module SHALL have parameter RAM_WORDS_LOG, default 14, meaning log2 of the internal RAM depth in 32-bit words.
REQ-002 The module SHALL have parameter IO_PORTS, default 4 (legal 1..4), meaning the number of I/O channels, each owning a 64-byte window.
REQ-003 The module SHALL have parameter IO_TIMEOUT, default 15 (legal 1..255), meaning the maximum number of IO_WAIT cycles before a timeout fault.
REQ-004 The module SHALL have the following ports, one per line:
  clk  in  1  clock, all logic on rising edge
  reset  in  1  synchronous, active-high reset
  dm_req  in  1  access request, sampled only in IDLE
  dm_we  in  1  write (1) / read (0)
  dm_addr  in  32  byte address
  dm_di  in  32  write data, right-aligned (byte in [7:0], half in [15:0])
  dm_be  in  4  byte enables: 1111, 0011, 1100, 0001, 0010, 0100, 1000
  is_signed  in  1  sign-extend reads (1) / zero-extend (0)
  dm_do  out  32  read data, extended and right-aligned
  dm_ready  out  1  one-cycle completion strobe
  dm_fault  out  1  access faulted, valid with dm_ready
  dm_cause  out  2  01 misaligned/illegal be, 10 unmapped, 11 IO timeout
  io_req  out  1  IO request, held until ack or timeout
  io_sel  out  IO_PORTS  one-hot channel select
  io_addr  out  6  offset within channel window
  io_we  out  1  IO write
  io_be  out  4  IO byte enables
  io_wdata  out  32  lane-shifted IO write data
  io_rdata  in  32  IO read data, valid with io_ack
  io_ack  in  1  IO completion

Function
REQ-005 Address map SHALL be: RAM at 0x1000_0000 to 0x1000_0000 + 4*2^RAM_WORDS_LOG - 1; IO at 0x8000_0000 to 0x8000_0000 + 64*IO_PORTS - 1, channel = dm_addr[7:6]; all other addresses, including 0x0000_0000-0x0000_0FFF, SHALL be unmapped.
REQ-006 Legal dm_be/dm_addr[1:0] pairs SHALL be 1111/00, 0011/00, 1100/10, 0001/00, 0010/01, 0100/10, 1000/11; any other pair is misaligned (cause 01), and misalignment takes priority over unmapped.
REQ-007 The FSM SHALL have states IDLE, IO_WAIT, RESP.
REQ-008 IDLE with dm_req=1 SHALL do the following: on a fault, go to RESP with dm_fault=1, no write, and dm_do=0; on a RAM hit, perform a byte-masked write (dm_we=1) or a synchronous read, then go to RESP; on an IO hit, register io_* and go to IO_WAIT.
REQ-009 In IO_WAIT, io_req SHALL be 1, and io_sel/io_addr/io_we/io_be/io_wdata SHALL be stable.
REQ-010 In IO_WAIT, io_ack=1 SHALL capture io_rdata, drop io_req on the next cycle, and go to RESP.
REQ-011 A wait counter SHALL clear on IO_WAIT entry and increment each IO_WAIT cycle without ack; reaching IO_TIMEOUT SHALL go to RESP with dm_fault=1, dm_cause=11, dm_do=0, and io_req dropped.
REQ-012 If io_ack and timeout coincide, io_ack SHALL win.
REQ-013 RESP SHALL assert dm_ready=1 for exactly one cycle with dm_do/dm_fault/dm_cause valid, then return to IDLE; dm_req is not sampled in RESP.
REQ-014 The requester SHALL hold dm_* inputs stable from request until dm_ready; a new request may be sampled in the cycle after dm_ready.
REQ-015 Latency SHALL be: RAM or fault, dm_ready in the cycle after the request is sampled; IO, dm_ready in the cycle after io_ack is sampled.
REQ-016 Write data SHALL be shifted to the lane selected by dm_be; a read SHALL select the lane(s) by registered dm_be and extend per registered is_signed.
REQ-017 RAM address SHALL be (dm_addr - 0x1000_0000)[RAM_WORDS_LOG+1:2]; io_addr SHALL be dm_addr[5:0].
REQ-018 Outside RESP, dm_do, dm_fault and dm_cause SHALL hold their last values; dm_ready SHALL be 0.

Reset
REQ-019 While reset=1 at a clock edge, the following SHALL be true after the edge: state=IDLE, dm_ready=0, dm_fault=0, dm_cause=00, dm_do=0, io_req=0, io_sel=0, io_we=0, counter=0.
REQ-020 Reset SHALL NOT alter RAM contents.
REQ-021 Reset during IO_WAIT SHALL drop io_req after the edge and produce no dm_ready for the aborted access.

Verification
REQ-022 Write 0xDEADBEEF, be=1111, to 0x1000_0010, then read with be=0100 to 0x1000_0012 and is_signed=1 -> dm_do=0xFFFFFFAD; with is_signed=0 -> 0x000000AD; each dm_ready arrives one cycle after request.
REQ-023 Read with be=1111 to 0x1000_0002 -> dm_ready with dm_fault=1, dm_cause=01, dm_do=0, RAM unchanged; read to 0x0000_0100 -> dm_cause=10.
REQ-024 Read from 0x8000_0084 (channel 2) with io_ack after 3 cycles and io_rdata=0x12345678 -> io_sel=0100, io_addr=0x04, dm_do=0x12345678, dm_fault=0.
REQ-025 IO write with no io_ack and IO_TIMEOUT=15 -> io_req held 15 cycles, then dm_ready with dm_cause=11; io_ack asserted on the timeout cycle -> normal completion.
REQ-026 Reset asserted during IO_WAIT -> io_req=0 next cycle, no dm_ready, and a following RAM read returns pre-reset data.
